// File: rtl/iod_pause_pkg.sv
// -----------------------------------------------------------------------------
// iod_pause_pkg
// Shared definitions for the IOD pause/delay sequencer:
//   - iod_state_t : sequencer FSM states
//   - TAP_W/TAP_MAX : delay-line tap position width and upper limit
//   - WAIT_W : width of the pre/post/recover wait counter
//   - clamp_steps() : applied step count saturated to the remaining tap range
// -----------------------------------------------------------------------------
package iod_pause_pkg;

    localparam int              TAP_W   = 7;
    localparam logic [TAP_W-1:0] TAP_MAX = 7'd127;
    localparam int              WAIT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_MOVE    = 3'd2,
        ST_GAP     = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RELEASE = 3'd5,
        ST_FINISH  = 3'd6
    } iod_state_t;

    // Number of taps that can actually be moved from 'tap' in direction 'dir'
    // without leaving 0..TAP_MAX.
    function automatic logic [TAP_W-1:0] clamp_steps(
        input logic             dir,
        input logic [TAP_W-1:0] tap,
        input logic [TAP_W-1:0] steps
    );
        logic [TAP_W-1:0] room;
        room = dir ? (TAP_MAX - tap) : tap;
        return (steps > room) ? room : steps;
    endfunction

endpackage

// File: rtl/iod_pause_wait_cnt.sv
// -----------------------------------------------------------------------------
// iod_pause_wait_cnt
// Loadable down-counter with a zero flag. Shared by the SETUP, HOLD and
// RELEASE phases of the sequencer; load takes priority over decrement and
// the count sticks at zero.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val on the next edge
//   i_load_val     : value to load
//   i_dec          : decrement by one (ignored at zero)
//   o_zero         : registered count is zero
// -----------------------------------------------------------------------------
import iod_pause_pkg::*;

module iod_pause_wait_cnt (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [WAIT_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_zero
);

    logic [WAIT_W-1:0] r_cnt;

    // Count register: load, decrement toward zero, or hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {WAIT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != {WAIT_W{1'b0}})) begin
            r_cnt <= r_cnt - {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {WAIT_W{1'b0}});

endmodule

// File: rtl/iod_pause_delay_seq.sv
// -----------------------------------------------------------------------------
// iod_pause_delay_seq
// Issues delay-line tap moves for one IOD lane group, wrapping each burst of
// moves in a HS_IO_CLK_PAUSE window, and tracks the tap position so requests
// saturate at 0 and TAP_MAX.
// Ports:
//   CLK, RESETN      : clock, asynchronous active-low reset
//   REQ              : move request (level, sampled only when idle)
//   REQ_DIR          : 1 = increment, 0 = decrement
//   REQ_STEPS[6:0]   : requested tap count
//   BUSY             : sequence in progress
//   DONE             : one-cycle completion pulse
//   CLAMPED          : applied count was smaller than requested (valid with DONE)
//   TAP[6:0]         : current tap position
//   HS_IO_CLK_PAUSE  : pause request to the lane-controller synchroniser
//   DELAY_MOVE       : one-cycle tap-move strobe
//   DELAY_DIR        : direction qualifier for DELAY_MOVE
// Outputs other than BUSY are registered from the current state, so they
// appear one cycle after the state is entered; BUSY is registered from the
// next state and therefore tracks the state itself.
// -----------------------------------------------------------------------------
import iod_pause_pkg::*;

module iod_pause_delay_seq #(
    parameter int PRE_WAIT  = 4,
    parameter int POST_WAIT = 4,
    parameter int RECOVER   = 2,
    parameter int TAP_INIT  = 0
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             REQ,
    input  logic             REQ_DIR,
    input  logic [TAP_W-1:0] REQ_STEPS,
    output logic             BUSY,
    output logic             DONE,
    output logic             CLAMPED,
    output logic [TAP_W-1:0] TAP,
    output logic             HS_IO_CLK_PAUSE,
    output logic             DELAY_MOVE,
    output logic             DELAY_DIR
);

    // Wait counter reload values: a phase lasting N cycles loads N-1.
    localparam logic [WAIT_W-1:0] PRE_LD  = WAIT_W'(PRE_WAIT - 1);
    localparam logic [WAIT_W-1:0] POST_LD = WAIT_W'(POST_WAIT - 1);
    localparam logic [WAIT_W-1:0] REC_LD  = WAIT_W'(RECOVER - 1);
    localparam logic [TAP_W-1:0]  TAP_RST = TAP_W'(TAP_INIT);

    iod_state_t        r_state;
    iod_state_t        w_state_nx;
    logic              w_accept;
    logic [TAP_W-1:0]  w_n;
    logic              w_ld;
    logic [WAIT_W-1:0] w_ld_val;
    logic              w_dec;
    logic              w_wait_zero;

    logic              r_dir;
    logic [TAP_W-1:0]  r_rem;
    logic              r_clamped;
    logic [TAP_W-1:0]  r_tap;
    logic              r_busy;
    logic              r_done;
    logic              r_pause;
    logic              r_move;
    logic              r_dly_dir;

    iod_pause_wait_cnt u_wait_cnt (
        .i_clk      (CLK),
        .i_rst_n    (RESETN),
        .i_load     (w_ld),
        .i_load_val (w_ld_val),
        .i_dec      (w_dec),
        .o_zero     (w_wait_zero)
    );

    // State register.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic and wait-counter control.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_ld       = 1'b0;
        w_ld_val   = {WAIT_W{1'b0}};
        w_dec      = 1'b0;
        w_n        = clamp_steps(REQ_DIR, r_tap, REQ_STEPS);
        case (r_state)
            ST_IDLE: begin
                if (REQ) begin
                    w_accept   = 1'b1;
                    w_state_nx = ST_SETUP;
                    w_ld       = 1'b1;
                    w_ld_val   = PRE_LD;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (w_wait_zero) begin
                    if (r_rem != {TAP_W{1'b0}}) begin
                        w_state_nx = ST_MOVE;
                    end else begin
                        w_state_nx = ST_HOLD;
                        w_ld       = 1'b1;
                        w_ld_val   = POST_LD;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_MOVE: begin
                // r_rem still counts the move being issued this cycle.
                if (r_rem == 7'd1) begin
                    w_state_nx = ST_HOLD;
                    w_ld       = 1'b1;
                    w_ld_val   = POST_LD;
                end else begin
                    w_state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_nx = ST_MOVE;
            end
            ST_HOLD: begin
                if (w_wait_zero) begin
                    w_state_nx = ST_RELEASE;
                    w_ld       = 1'b1;
                    w_ld_val   = REC_LD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (w_wait_zero) begin
                    w_state_nx = ST_FINISH;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_FINISH: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Request latch, remaining-move counter and tap position.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_dir     <= 1'b0;
            r_rem     <= {TAP_W{1'b0}};
            r_clamped <= 1'b0;
            r_tap     <= TAP_RST;
        end else if (w_accept) begin
            r_dir     <= REQ_DIR;
            r_rem     <= w_n;
            r_clamped <= (w_n != REQ_STEPS);
        end else if (r_state == ST_MOVE) begin
            r_rem <= r_rem - 7'd1;
            r_tap <= r_dir ? (r_tap + 7'd1) : (r_tap - 7'd1);
        end else begin
            r_rem <= r_rem;
            r_tap <= r_tap;
        end
    end

    // Registered outputs decoded from the state.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pause   <= 1'b0;
            r_move    <= 1'b0;
            r_dly_dir <= 1'b0;
        end else begin
            r_busy    <= (w_state_nx != ST_IDLE);
            r_done    <= (r_state == ST_FINISH);
            r_pause   <= (r_state == ST_SETUP) || (r_state == ST_MOVE) ||
                         (r_state == ST_GAP)   || (r_state == ST_HOLD);
            r_move    <= (r_state == ST_MOVE);
            r_dly_dir <= ((r_state != ST_IDLE) && (r_state != ST_FINISH)) ? r_dir : 1'b0;
        end
    end

    assign BUSY            = r_busy;
    assign DONE            = r_done;
    assign CLAMPED         = r_clamped;
    assign TAP             = r_tap;
    assign HS_IO_CLK_PAUSE = r_pause;
    assign DELAY_MOVE      = r_move;
    assign DELAY_DIR       = r_dly_dir;

endmodule

// File: tb/tb_iod_pause_delay_seq.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for iod_pause_delay_seq. The driver computes each
// request's applied step count, clamp flag, final tap and event times from the
// timing rules and queues them; the monitor checks every pause edge, move
// strobe and DONE against the queue head.
// -----------------------------------------------------------------------------
module tb_iod_pause_delay_seq;

    localparam int PRE  = 4;
    localparam int POST = 4;
    localparam int REC  = 2;
    localparam int TINIT = 0;

    typedef struct {
        int t0;
        int n;
        int clamp;
        int dir;
        int tap;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       req_dir;
    logic [6:0] req_steps;
    logic       busy;
    logic       done;
    logic       clamped;
    logic [6:0] tap;
    logic       pause;
    logic       dmove;
    logic       ddir;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   timeouts = 0;
    int   model_tap = TINIT;
    bit   tb_done = 1'b0;

    // monitor-owned state
    int   moves = 0;
    int   last_move = -100;
    bit   pause_prev = 1'b0;
    bit   rst_checked = 1'b0;

    iod_pause_delay_seq #(
        .PRE_WAIT  (PRE),
        .POST_WAIT (POST),
        .RECOVER   (REC),
        .TAP_INIT  (TINIT)
    ) dut (
        .CLK             (clk),
        .RESETN          (rst_n),
        .REQ             (req),
        .REQ_DIR         (req_dir),
        .REQ_STEPS       (req_steps),
        .BUSY            (busy),
        .DONE            (done),
        .CLAMPED         (clamped),
        .TAP             (tap),
        .HS_IO_CLK_PAUSE (pause),
        .DELAY_MOVE      (dmove),
        .DELAY_DIR       (ddir)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fall_cyc(exp_t e);
        return e.t0 + 1 + PRE + ((e.n > 0) ? (2 * e.n - 1) : 0) + POST;
    endfunction

    task automatic chk(string name, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            if (!rst_checked) begin
                chk("rst_pause",   int'(pause),   0);
                chk("rst_busy",    int'(busy),    0);
                chk("rst_done",    int'(done),    0);
                chk("rst_clamped", int'(clamped), 0);
                chk("rst_tap",     int'(tap),     TINIT);
                chk("rst_move",    int'(dmove),   0);
                chk("rst_dir",     int'(ddir),    0);
                rst_checked = 1'b1;
            end
            q.delete();
            moves = 0;
            last_move = -100;
            pause_prev = 1'b0;
        end else begin
            rst_checked = 1'b0;
            if (dmove) begin
                if (q.size() == 0) begin
                    chk("move_outstanding", q.size(), 1);
                end else begin
                    chk("move_time", cyc, q[0].t0 + 1 + PRE + 2 * moves);
                    chk("move_dir", int'(ddir), q[0].dir);
                end
                chk("move_under_pause", int'(pause), 1);
                if (moves > 0) chk("move_spacing", int'((cyc - last_move) >= 2), 1);
                moves++;
                last_move = cyc;
            end
            if (pause && !pause_prev) begin
                if (q.size() == 0) chk("pause_outstanding", q.size(), 1);
                else chk("pause_rise", cyc, q[0].t0 + 1);
            end
            if (!pause && pause_prev && (q.size() > 0)) begin
                chk("pause_fall", cyc, fall_cyc(q[0]));
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("done_outstanding", q.size(), 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("done_time",  cyc, fall_cyc(e) + REC);
                    chk("move_count", moves, e.n);
                    chk("clamped",    int'(clamped), e.clamp);
                    chk("tap",        int'(tap), e.tap);
                end
                moves = 0;
            end
            pause_prev = pause;
        end
        if (tb_done) begin
            chk("queue_empty", q.size(), 0);
            chk("timeouts", timeouts, 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        if (cyc > 50000) begin
            chk("watchdog", int'(cyc <= 50000), 1);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && (k < 3000)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) timeouts++;
    endtask

    task automatic wait_moves(int cnt);
        int seen;
        int k;
        seen = 0;
        k = 0;
        while ((seen < cnt) && (k < 3000)) begin
            @(negedge clk);
            if (dmove) seen++;
            k++;
        end
        if (k >= 3000) timeouts++;
    endtask

    task automatic issue(int dir, int steps);
        exp_t e;
        int   room;
        int   n;
        wait_idle();
        room = (dir != 0) ? (127 - model_tap) : model_tap;
        n = (steps < room) ? steps : room;
        e.t0 = cyc + 1;
        e.n = n;
        e.clamp = (n != steps) ? 1 : 0;
        e.dir = dir;
        model_tap = (dir != 0) ? (model_tap + n) : (model_tap - n);
        e.tap = model_tap;
        q.push_back(e);
        req = 1'b1;
        req_dir = (dir != 0);
        req_steps = 7'(steps);
        @(negedge clk);
        req = 1'b0;
        req_steps = 7'($urandom_range(0, 127));
    endtask

    initial begin
        rst_n = 1'b1;
        req = 1'b0;
        req_dir = 1'b0;
        req_steps = 7'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        issue(1, 3);        // basic increment
        issue(1, 0);        // zero steps
        issue(1, 122);      // tap -> 125
        issue(1, 5);        // clamp at top
        issue(0, 126);      // tap -> 1
        issue(0, 4);        // clamp at bottom

        // request while busy: pulse REQ during HOLD of a 2-step sequence
        issue(1, 2);
        wait_moves(2);
        repeat (2) @(negedge clk);
        req = 1'b1;
        req_dir = 1'b1;
        req_steps = 7'd5;
        @(negedge clk);
        req = 1'b0;

        // reset after second move of a 4-step request
        issue(1, 4);
        wait_moves(2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_tap = TINIT;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(1, 6);

        for (int i = 0; i < 25; i++) begin
            int d;
            int s;
            d = int'($urandom_range(0, 1));
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                             : int'($urandom_range(0, 12));
            issue(d, s);
        end

        wait_idle();
        repeat (4) @(negedge clk);
        tb_done = 1'b1;
        repeat (20) @(negedge clk);
        $display("FAIL end_of_test: monitor did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
